// File: rtl/mcu51_pkg.sv
// Shared definitions for the MCU51 multiply/divide unit.
// Holds the operation encoding, the engine state enum and the datapath sizes.
package mcu51_pkg;

    // Operation select encoding
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Iterations per operation (one operand bit per cycle)
    localparam int unsigned MDU_ITER  = 8;
    localparam int unsigned MDU_W     = 8;
    localparam int unsigned MDU_CNT_W = 4;

    // Engine states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 8-bit MUL AB / DIV AB engine (8051 style).
// An accepted start latches the operands, then 8 CALC cycles process one operand
// bit each (shift-and-add multiply or restoring divide), then DONE publishes the
// results. busy/done/results are registered one cycle behind the state register,
// so busy is high for the 8 cycles after the first CALC edge and done pulses one
// cycle after DONE.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, op           request strobe, operation (0 = MUL, 1 = DIV)
//   a_data, b_data      operands (only sampled when start is accepted)
//   busy, done          operation in progress, one-cycle result-valid pulse
//   a_out, b_out        MUL: product low/high byte; DIV: quotient/remainder
//   ov_out, cy_out      PSW.OV and PSW.CY results (CY is always 0)
//
// Configuration: define MCU51_MDU_DIV_EN to build the divider datapath. Without
// it, op=1 still completes with normal timing and returns A=0, B=0, OV=1.
module mul_div_unit
    import mcu51_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [MDU_W-1:0]     a_data,
    input  logic [MDU_W-1:0]     b_data,
    output logic                 busy,
    output logic                 done,
    output logic [MDU_W-1:0]     a_out,
    output logic [MDU_W-1:0]     b_out,
    output logic                 ov_out,
    output logic                 cy_out
);

    localparam int unsigned W  = MDU_W;
    localparam int unsigned AW = 2 * MDU_W;

    mdu_state_e             state_q, state_d;
    logic [MDU_CNT_W-1:0]   cnt_q,   cnt_d;
    logic [AW-1:0]          acc_q,   acc_d;
    logic [W-1:0]           opb_q,   opb_d;
    logic                   op_q,    op_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
    logic [W-1:0]           a_q,     a_d;
    logic [W-1:0]           b_q,     b_d;
    logic                   ov_q,    ov_d;

    logic                   accept_c;
    logic [AW-1:0]          mul_step_c;
    logic [W:0]             mul_sum_c;

`ifdef MCU51_MDU_DIV_EN
    logic [AW-1:0]          div_step_c;
    logic [W:0]             rem_shift_c;
    logic [W:0]             rem_diff_c;
`endif

    // Start is honoured only outside CALC; requests during CALC are dropped
    assign accept_c = start && (state_q != CALC);

    // One shift-and-add step: acc = {partial_high, multiplier}, shifted right
    // with the add carry entering at the top
    always_comb begin
        mul_sum_c  = {1'b0, acc_q[AW-1:W]};
        if (acc_q[0]) begin
            mul_sum_c = {1'b0, acc_q[AW-1:W]} + {1'b0, opb_q};
        end
        mul_step_c = {mul_sum_c, acc_q[W-1:1]};
    end

`ifdef MCU51_MDU_DIV_EN
    // One restoring-division step: acc = {remainder, dividend/quotient};
    // a zero divisor naturally yields quotient 0xFF and remainder = dividend
    always_comb begin
        rem_shift_c = {acc_q[AW-1:W], acc_q[W-1]};
        rem_diff_c  = rem_shift_c - {1'b0, opb_q};
        if (rem_diff_c[W]) begin
            div_step_c = {rem_shift_c[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            div_step_c = {rem_diff_c[W-1:0], acc_q[W-2:0], 1'b1};
        end
    end
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        op_d    = op_q;
        busy_d  = (state_q == CALC);
        done_d  = (state_q == DONE);
        a_d     = a_q;
        b_d     = b_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    acc_d   = {{W{1'b0}}, a_data};
                    opb_d   = b_data;
                    op_d    = op;
                end
            end

            CALC: begin
                if (op_q == OP_MUL) begin
                    acc_d = mul_step_c;
                end else begin
`ifdef MCU51_MDU_DIV_EN
                    acc_d = div_step_c;
`else
                    acc_d = acc_q;
`endif
                end
                cnt_d = cnt_q + MDU_CNT_W'(1);
                if (cnt_q == MDU_CNT_W'(MDU_ITER - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end

            DONE: begin
                // Publish results; they surface together with the done pulse
                if (op_q == OP_MUL) begin
                    a_d  = acc_q[W-1:0];
                    b_d  = acc_q[AW-1:W];
                    ov_d = |acc_q[AW-1:W];
                end else begin
`ifdef MCU51_MDU_DIV_EN
                    a_d  = acc_q[W-1:0];
                    b_d  = acc_q[AW-1:W];
                    ov_d = (opb_q == '0);
`else
                    a_d  = '0;
                    b_d  = '0;
                    ov_d = 1'b1;
`endif
                end
                state_d = IDLE;
                if (accept_c) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    acc_d   = {{W{1'b0}}, a_data};
                    opb_d   = b_data;
                    op_d    = op;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            op_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ov_q    <= ov_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_out  = a_q;
    assign b_out  = b_q;
    assign ov_out = ov_q;
    // MUL AB and DIV AB always clear CY
    assign cy_out = 1'b0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: table of MUL/DIV vectors with a result
// scoreboard, plus hand-written sequences for ignored start, mid-operation reset
// and back-to-back operations.
module tb_mul_div_unit;
    import mcu51_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic [7:0] b_data = 8'h00;
    logic       busy, done, ov_out, cy_out;
    logic [7:0] a_out, b_out;

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a_data (a_data),
        .b_data (b_data),
        .busy   (busy),
        .done   (done),
        .a_out  (a_out),
        .b_out  (b_out),
        .ov_out (ov_out),
        .cy_out (cy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       eov;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ov;
    } res_t;

    res_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] hold_a = 8'h00;
    logic [7:0] hold_b = 8'h00;
    logic       hold_ov = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t exp_of(input vec_t v);
        res_t r;
        r.a  = v.ea;
        r.b  = v.eb;
        r.ov = v.eov;
`ifndef MCU51_MDU_DIV_EN
        if (v.op == OP_DIV) begin
            r.a  = 8'h00;
            r.b  = 8'h00;
            r.ov = 1'b1;
        end
`endif
        return r;
    endfunction

    // Scoreboard: compare each done pulse against the oldest expected result,
    // and require outputs to hold steady while busy
    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            if (done) begin
                check("done_busy_overlap", 16'(busy), 16'h0);
                check("cy_out", 16'(cy_out), 16'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    e = exp_q.pop_front();
                    check("a_out", 16'(a_out), 16'(e.a));
                    check("b_out", 16'(b_out), 16'(e.b));
                    check("ov_out", 16'(ov_out), 16'(e.ov));
                    hold_a  = e.a;
                    hold_b  = e.b;
                    hold_ov = e.ov;
                end
            end else if (busy) begin
                check("hold_during_calc", {a_out, b_out} ^ 16'(ov_out),
                      {hold_a, hold_b} ^ 16'(hold_ov));
            end
        end
    end

    task automatic issue(input vec_t v);
        @(negedge clk);
        start  = 1'b1;
        op     = v.op;
        a_data = v.a;
        b_data = v.b;
        exp_q.push_back(exp_of(v));
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 1'($urandom);
        a_data = 8'($urandom);
        b_data = 8'($urandom);
    endtask

    // Walk the cycles after acceptance: busy must be high exactly 8 cycles and
    // done must appear in cycle 9. Optionally inject an ignored start, or chain
    // the next operation into the done cycle.
    task automatic measure(input string tag, input int inject_c, input bit chain, input vec_t nv);
        int busy_cnt;
        int done_c;
        busy_cnt = 0;
        done_c   = -1;
        for (int c = 0; c < 20 && done_c < 0; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_c = c;
            if (c == inject_c) begin
                start  = 1'b1;
                op     = OP_DIV;
                a_data = 8'hFF;
                b_data = 8'h01;
            end
            if (c == inject_c + 1) start = 1'b0;
            if (done && chain) begin
                start  = 1'b1;
                op     = nv.op;
                a_data = nv.a;
                b_data = nv.b;
                exp_q.push_back(exp_of(nv));
            end
        end
        check({tag, "_latency"}, 16'(done_c), 16'd9);
        check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd8);
    endtask

    vec_t vt[12];
    vec_t none;
    vec_t v_ff, v_div;
    int   spurious;

    initial begin
        vt[0]  = '{OP_MUL, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1};
        vt[1]  = '{OP_MUL, 8'h0C, 8'h10, 8'hC0, 8'h00, 1'b0};
        vt[2]  = '{OP_DIV, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0};
        vt[3]  = '{OP_DIV, 8'h37, 8'h00, 8'hFF, 8'h37, 1'b1};
        vt[4]  = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1};
        vt[5]  = '{OP_DIV, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0};
        vt[6]  = '{OP_MUL, 8'h00, 8'h7F, 8'h00, 8'h00, 1'b0};
        vt[7]  = '{OP_MUL, 8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vt[8]  = '{OP_MUL, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1};
        vt[9]  = '{OP_DIV, 8'h07, 8'h09, 8'h00, 8'h07, 1'b0};
        vt[10] = '{OP_DIV, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0};
        vt[11] = '{OP_DIV, 8'h80, 8'h80, 8'h01, 8'h00, 1'b0};
        none   = '{OP_MUL, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_outputs", {a_out, b_out}, 16'h0000);
        check("rst_flags", {14'h0, ov_out, cy_out}, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven operations
        for (int i = 0; i < 12; i++) begin
            issue(vt[i]);
            measure($sformatf("vec%0d", i), -1, 1'b0, none);
        end

        // Start pulsed during cycle 3 of a MUL must be ignored
        issue('{OP_MUL, 8'h03, 8'h05, 8'h0F, 8'h00, 1'b0});
        measure("ignore_start", 3, 1'b0, none);

        // Reset in cycle 5 of MUL FF x FF aborts it with no done pulse
        issue('{OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1});
        for (int c = 0; c < 6; c++) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        hold_a  = 8'h00;
        hold_b  = 8'h00;
        hold_ov = 1'b0;
        #1;
        check("abort_rst_outputs", {a_out, b_out}, 16'h0000);
        check("abort_rst_ctrl", {12'h0, busy, done, ov_out, cy_out}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        check("abort_no_done", 16'(spurious), 16'h0);
        check("abort_outputs_zero", {a_out, b_out}, 16'h0000);

        // First operation after reset has normal timing
        issue(vt[1]);
        measure("post_rst", -1, 1'b0, none);

        // Back-to-back: DIV started in the done cycle of MUL FF x FF
        v_ff  = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1};
        v_div = '{OP_DIV, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0};
        issue(v_ff);
        measure("b2b_first", -1, 1'b1, v_div);
        @(posedge clk);
        #1;
        start = 1'b0;
        measure("b2b_second", -1, 1'b0, none);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL provide these ports, in this order:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe, sampled on a rising edge.
- op  in  1  operation select: 0 = MUL AB, 1 = DIV AB.
- a_data  in  8  accumulator operand.
- b_data  in  8  B-register operand.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when results are valid.
- a_out  out  8  MUL: product low byte. DIV: quotient.
- b_out  out  8  MUL: product high byte. DIV: remainder.
- ov_out  out  1  PSW.OV result.
- cy_out  out  1  PSW.CY result; always 0.
REQ-002 The block SHALL use a single clock; reset SHALL be asynchronous and active-high.

Function
REQ-003 The block SHALL be an iterative 8-bit engine with states IDLE, CALC and DONE.
REQ-004 Start acceptance:
- start SHALL be accepted when busy=0, i.e. in IDLE or DONE.
- On acceptance the block SHALL latch a_data, b_data and op, clear the iteration counter, and enter CALC.
REQ-005 CALC SHALL run exactly 8 cycles, one operand bit per cycle, using a 4-bit counter 0..7.
- After count 7 the block SHALL go to DONE.
REQ-006 Timing, with start accepted at edge N:
- busy=1 from N+1 through N+8.
- done=1 for exactly the cycle after edge N+9, with busy=0 in that cycle.
- Latency SHALL be identical for MUL, DIV and divide-by-zero.
REQ-007 DONE SHALL return to IDLE after one cycle unless start is accepted in that cycle.
REQ-008 a_out, b_out and ov_out SHALL hold their values from done until the next done or reset.
- They SHALL NOT change during CALC.
REQ-009 MUL: the block SHALL compute the 16-bit product {b_out, a_out} = a_data * b_data by shift-and-add.
- ov_out=1 if and only if the product is greater than 0xFF.
REQ-010 DIV: the block SHALL compute a_out = a_data / b_data and b_out = a_data mod b_data by restoring division.
- ov_out=0.
REQ-011 DIV with b_data=0 SHALL produce ov_out=1, a_out=0xFF and b_out=a_data, with unchanged latency.
REQ-012 cy_out SHALL be 0 at reset and after every operation.
REQ-013 start asserted while busy=1 SHALL be ignored, with no queuing and no effect on the current operation.
REQ-014 Operand inputs SHALL be don't-care except in the cycle in which start is accepted.

Reset
REQ-015 With rst=1, immediately and regardless of clk, the block SHALL force:
- state=IDLE.
- busy=0, done=0.
- a_out=0x00, b_out=0x00, ov_out=0, cy_out=0.
- all internal registers to 0.
REQ-016 Reset during CALC SHALL abort the operation, and no done pulse SHALL follow.
REQ-017 After rst deasserts, the first accepted start SHALL behave as in REQ-006.

Configuration
REQ-018 The block SHALL use the macro MCU51_MDU_DIV_EN.
- Defined: DIV SHALL be implemented per REQ-010 and REQ-011.
- Undefined: the divider datapath SHALL be omitted.
  - op=1 SHALL still complete with REQ-006 timing.
  - It SHALL produce a_out=0x00, b_out=0x00 and ov_out=1.
  - MUL SHALL be unaffected.

Structure
REQ-019 The shared package mcu51_pkg SHALL hold:
- the op encoding constants OP_MUL=1'b0 and OP_DIV=1'b1;
- the state enum (IDLE, CALC, DONE);
- MDU_ITER=8.
REQ-020 The block SHALL be a single module with no sub-module.
- The datapath (a 16-bit accumulator/remainder shift register plus an 8-bit operand register) SHALL be inline.

Verification
REQ-021 The bench SHALL cover these scenarios:
- MUL 0x50 x 0xA0: a_out=0x00, b_out=0x32, ov=1, cy=0; done exactly 9 cycles after start.
- MUL 0x0C x 0x10: a_out=0xC0, b_out=0x00, ov=0.
- DIV 0xFB / 0x12: a_out=0x0D, b_out=0x11, ov=0; busy high for 8 cycles.
- DIV 0x37 / 0x00: a_out=0xFF, b_out=0x37, ov=1; same latency. With MCU51_MDU_DIV_EN undefined: a_out=0x00, b_out=0x00, ov=1.
- start pulsed at cycle 3 of a MUL, then rst pulsed at cycle 5 of a new MUL 0xFF x 0xFF:
  - the first pulse is ignored;
  - after reset, all outputs are 0 and no done pulse follows.
- Back-to-back: MUL 0xFF x 0xFF, then DIV 0x64 / 0x07 started in the done cycle:
  - first result a_out=0x01, b_out=0xFE, ov=1;
  - second result a_out=0x0E, b_out=0x02, ov=0, 9 cycles later.
